// File: rtl/gray_code_counter.sv
// Up/down counter, binary state presented as binary + Gray; Gray load port. GRAY_CODE_COUNTER_SAT_EN selects saturation.
// Latency: one cycle from sampled inputs to all registered outputs.
// Backpressure: none; en/load are accepted every cycle, rst > load > en > hold.
module gray_code_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             at_max;
    logic             at_min;

    // Gray decode: each binary bit is the xor of all Gray bits at or above it.
    always_comb begin
        load_bin = '0;
        load_bin[WIDTH-1] = load_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ load_gray[i];
        end
    end

    assign at_max = &binary;
    assign at_min = ~|binary;

    always_comb begin
        cnt_nxt = binary;
        ovf_nxt = 1'b0;
        if (load) begin
            cnt_nxt = load_bin;
        end else if (en) begin
            if (up) begin
                ovf_nxt = at_max;
`ifdef GRAY_CODE_COUNTER_SAT_EN
                cnt_nxt = at_max ? binary : binary + ONE;
`else
                cnt_nxt = binary + ONE;
`endif
            end else begin
                ovf_nxt = at_min;
`ifdef GRAY_CODE_COUNTER_SAT_EN
                cnt_nxt = at_min ? binary : binary - ONE;
`else
                cnt_nxt = binary - ONE;
`endif
            end
        end
    end

    // Gray is derived from the next count so both outputs update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            binary <= '0;
            gray   <= '0;
            ovf    <= 1'b0;
        end else begin
            binary <= cnt_nxt;
            gray   <= cnt_nxt ^ (cnt_nxt >> 1);
            ovf    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: directed cases on a 4-bit instance, randomized run on an 8-bit instance
// against an integer reference model. Honours GRAY_CODE_COUNTER_SAT_EN like the design.
module tb_gray_code_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 4-bit instance for the directed cases
    logic       rst4 = 1'b1, en4 = 1'b0, up4 = 1'b0, load4 = 1'b0;
    logic [3:0] lg4 = '0;
    logic [3:0] bin4, gray4;
    logic       ovf4;

    // 8-bit instance for the randomized run
    logic       rst8 = 1'b1, en8 = 1'b0, up8 = 1'b0, load8 = 1'b0;
    logic [7:0] lg8 = '0;
    logic [7:0] bin8, gray8;
    logic       ovf8;

    gray_code_counter #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .up(up4), .load(load4),
        .load_gray(lg4), .binary(bin4), .gray(gray4), .ovf(ovf4)
    );

    gray_code_counter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8),
        .load_gray(lg8), .binary(bin8), .gray(gray8), .ovf(ovf8)
    );

`ifdef GRAY_CODE_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: search for the binary value whose Gray code matches.
    function automatic int gdec(input int g, input int w);
        for (int b = 0; b < (1 << w); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    function automatic int genc(input int b);
        return b ^ (b >> 1);
    endfunction

    logic [3:0] gray_seq [12];

    initial begin
        int m;
        int mo;
        int maxv;
        logic [7:0] prev_gray;
        bit stepped;

        gray_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                     4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110};

        // reset state
        step();
        check("rst_bin", bin4, 0);
        check("rst_gray", gray4, 0);
        check("rst_ovf", ovf4, 0);

        // 12 up steps through the Gray sequence
        rst4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("seq_bin", bin4, i);
            check("seq_gray", gray4, gray_seq[i]);
            check("seq_ovf", ovf4, 0);
            step();
        end

        // load 1000 (binary 15), then one up step across the top
        en4 = 1'b0; load4 = 1'b1; lg4 = 4'b1000;
        step();
        check("ld15_bin", bin4, 15);
        check("ld15_gray", gray4, 4'b1000);
        check("ld15_ovf", ovf4, 0);
        load4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
        step();
        check("top_bin", bin4, SAT ? 15 : 0);
        check("top_gray", gray4, SAT ? 4'b1000 : 4'b0000);
        check("top_ovf", ovf4, 1);
        en4 = 1'b0;
        step();
        check("top_ovf_drop", ovf4, 0);

        // from reset, down steps across the bottom
        rst4 = 1'b1;
        step();
        rst4 = 1'b0; en4 = 1'b1; up4 = 1'b0;
        step();
        check("bot_bin", bin4, SAT ? 0 : 15);
        check("bot_gray", gray4, SAT ? 4'b0000 : 4'b1000);
        check("bot_ovf", ovf4, 1);
        step();
        check("bot2_bin", bin4, SAT ? 0 : 14);
        check("bot2_ovf", ovf4, SAT ? 1 : 0);

        // load wins over count
        load4 = 1'b1; lg4 = 4'b1011; en4 = 1'b1; up4 = 1'b1;
        step();
        check("ldpri_bin", bin4, 13);
        check("ldpri_gray", gray4, 4'b1011);
        check("ldpri_ovf", ovf4, 0);

        // back-to-back loads
        lg4 = 4'b0110;
        step();
        check("b2b1_bin", bin4, 4);
        lg4 = 4'b0011;
        step();
        check("b2b2_bin", bin4, 2);
        check("b2b2_gray", gray4, 4'b0011);

        // count to 6, then reset together with load and en
        load4 = 1'b0; rst4 = 1'b1;
        step();
        rst4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
        repeat (6) step();
        check("pre_rst_bin", bin4, 6);
        rst4 = 1'b1; load4 = 1'b1; lg4 = 4'b1111;
        step();
        check("midrst_bin", bin4, 0);
        check("midrst_gray", gray4, 0);
        check("midrst_ovf", ovf4, 0);
        rst4 = 1'b1; load4 = 1'b0; en4 = 1'b0;

        // randomized run on the 8-bit instance
        maxv = 255;
        m = 0;
        mo = 0;
        step();
        check("r8_rst_bin", bin8, 0);
        rst8 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            rst8  = ($urandom_range(0, 199) == 0);
            load8 = ($urandom_range(0, 7) == 0);
            en8   = ($urandom_range(0, 3) != 0);
            up8   = $urandom_range(0, 1);
            lg8   = $urandom_range(0, 255);
            prev_gray = gray8;
            stepped = 1'b0;
            if (rst8) begin
                m = 0; mo = 0;
            end else if (load8) begin
                m = gdec(lg8, 8); mo = 0;
            end else if (en8) begin
                if (up8) begin
                    mo = (m == maxv);
                    if (m == maxv) m = SAT ? m : 0;
                    else begin m = m + 1; stepped = 1'b1; end
                    if (!SAT && mo) stepped = 1'b1;
                end else begin
                    mo = (m == 0);
                    if (m == 0) m = SAT ? m : maxv;
                    else begin m = m - 1; stepped = 1'b1; end
                    if (!SAT && mo) stepped = 1'b1;
                end
            end else begin
                mo = 0;
            end
            step();
            check("r8_bin", bin8, m);
            check("r8_gray", gray8, genc(m));
            check("r8_ovf", ovf8, mo);
            check("r8_gray_prop", gray8, bin8 ^ (bin8 >> 1));
            if (stepped) check("r8_gray_1bit", $countones(gray8 ^ prev_gray), 1);
            else if (!rst8 && !load8) check("r8_gray_hold", gray8, prev_gray);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_code_counter.md
# gray_code_counter

Parametrised up/down counter that keeps its state in binary and presents it in both binary and reflected-binary Gray code. Both outputs are registered. The counter can be loaded from a Gray-coded value, using an internal Gray-to-binary decode. It extends the team's combinational binary-to-Gray converter into a clocked, width-generic block. It is intended for position encoders, CDC pointer generation and sequence generators.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..32.
- `clk` input, 1: clock; all state changes on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `en` input, 1: count enable; one step per cycle while high.
- `up` input, 1: direction; 1 = increment, 0 = decrement; sampled only when `en`=1.
- `load` input, 1: synchronous load strobe.
- `load_gray` input, WIDTH: Gray-coded load value; decoded to binary internally.
- `binary` output, WIDTH: registered binary count.
- `gray` output, WIDTH: registered Gray code of `binary`; always equals `binary ^ (binary >> 1)`.
- `ovf` output, 1: registered one-cycle pulse on boundary crossing; meaning depends on configuration.

## Operation
- The state is a WIDTH-bit binary register `cnt`. The `gray` register is computed from the next value of `cnt`, so `binary` and `gray` always update in the same cycle and never disagree.
- Priority per edge: `rst` > `load` > `en` > hold.
- Reset: `binary`=0, `gray`=0, `ovf`=0.
- Load:
  - The decode is `cnt[WIDTH-1] = load_gray[WIDTH-1]` and `cnt[i] = cnt[i+1] ^ load_gray[i]`.
  - `ovf`=0 on a load cycle.
  - `en` and `up` are ignored on a load cycle.
- Count:
  - Increment when `up`=1, decrement when `up`=0.
  - Arithmetic is modulo 2^WIDTH unless saturation is compiled in (see Configuration).
- Hold: with `en`=0 and `load`=0, all outputs keep their value and `ovf`=0.
- Gray property: every count step changes exactly one bit of `gray`, including the wrap step.
- Boundaries in wrap mode:
  - Up at 2^WIDTH-1 gives 0 and `ovf`=1.
  - Down at 0 gives 2^WIDTH-1 and `ovf`=1.
- Reset mid-count: takes effect on that edge regardless of `load` or `en`; there is no residual state.

## Timing
- Latency is one cycle: inputs sampled at edge N are reflected on all outputs after edge N.
- `ovf` is high for exactly the one cycle following the edge that crossed the boundary. It is re-asserted on every crossing, including consecutive crossings (e.g. repeated down steps at WIDTH-wide wrap alternation).
- There is no combinational path from any input to any output.
- Back-to-back loads are allowed; each load value appears one cycle after it is sampled.

## Configuration
- Macro: `GRAY_CODE_COUNTER_SAT_EN`.
- Undefined (default): wrap mode as described above. `ovf` pulses on wrap.
- Defined: saturating mode.
  - Up at 2^WIDTH-1 holds the count; down at 0 holds the count.
  - `ovf` pulses for one cycle on each attempted step past the limit, and stays high on consecutive attempted steps.
  - `gray` does not change while the counter is saturated.
  - Load and reset behaviour are unchanged.

## Test plan
- Reset, then `en`=1, `up`=1 for 12 cycles (WIDTH=4) -> `gray` steps 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110, and `binary` steps 0..11.
- Load `load_gray`=1000 (binary 15), then one up step:
  - Wrap build: `binary`=0, `gray`=0000, `ovf`=1 for one cycle.
  - SAT build: `binary`=15, `gray`=1000, `ovf`=1.
- From reset, one down step:
  - Wrap build: `binary`=1111, `gray`=1000, `ovf`=1.
  - SAT build: `binary`=0, `ovf`=1.
- `load`=1 with `load_gray`=1011 and `en`=1, `up`=1 in the same cycle -> `binary`=1101 (13), `gray`=1011, `ovf`=0; load wins over the count.
- Count up to 6, then assert `rst` together with `load`=1 and `en`=1 -> next cycle `binary`=0, `gray`=0, `ovf`=0.
- Random `en`/`up`/`load` for 10k cycles at WIDTH=8 -> the scoreboard confirms the following every cycle:
  - `gray == binary ^ (binary>>1)`.
  - Single-bit Gray change on every count step.
  - Correct `ovf` behaviour.
